// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front-end: generates fetch PCs, handshakes with instruction memory,
// buffers returned words with their PCs and hands them to the CPU; redirects flush everything.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {FETCH, DRAIN} state_e;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } entry_t;

  state_e                 state_q;
  logic [31:0]            fetch_pc_q;
  logic [31:0]            drain_addr_q;
  logic [PW-1:0]          head_q;
  logic [PW-1:0]          tail_q;
  logic [CW-1:0]          count_q;
  entry_t [DEPTH-1:0]     queue_q;

  logic        full;
  logic        handshake;
  logic        push;
  logic        pop;
  logic [31:0] target;
  logic        unused_rpc_lsbs;

  assign full   = (count_q == CW'(DEPTH));
  assign target = {redirect_pc[31:2], 2'b00};
  assign unused_rpc_lsbs = ^redirect_pc[1:0];

  // DRAIN keeps the abandoned request alive so the memory handshake stays stable;
  // gating with reset keeps the request low while reset is held.
  assign imem_req  = reset && ((state_q == DRAIN) || !full);
  assign imem_addr = (state_q == DRAIN) ? drain_addr_q : fetch_pc_q;
  assign handshake = imem_req && imem_ready;
  assign push      = handshake && (state_q == FETCH) && !redirect;

  assign inst_valid  = reset && (count_q != '0) && !redirect;
  assign pop         = inst_valid && inst_ready;
  assign instruction = queue_q[head_q].word;
  assign inst_pc     = queue_q[head_q].pc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= FETCH;
      fetch_pc_q   <= RESET_PC;
      drain_addr_q <= RESET_PC;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      queue_q      <= '0;
    end else if (redirect) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fetch_pc_q <= target;
      // A request left hanging must be drained; a drain whose handshake lands now is done.
      if (state_q == FETCH && imem_req && !imem_ready) begin
        state_q      <= DRAIN;
        drain_addr_q <= fetch_pc_q;
      end else if (state_q == DRAIN && imem_ready) begin
        state_q <= FETCH;
      end
    end else begin
      if (state_q == DRAIN && imem_ready)
        state_q <= FETCH;
      if (push) begin
        queue_q[tail_q].word <= imem_rdata;
        queue_q[tail_q].pc   <= fetch_pc_q;
        tail_q               <= tail_q + 1'b1;
        fetch_pc_q           <= fetch_pc_q + 32'd4;
      end
      if (pop)
        head_q <= head_q + 1'b1;
      if (push && !pop)
        count_q <= count_q + 1'b1;
      else if (!push && pop)
        count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector tables, randomized traffic against a
// queue-based reference model, and a wrap/reset sequence on a second instance.
module tb_instruction_fetch_unit;
  localparam int DEPTH = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset = 1'b0;
  logic        imem_req, imem_ready, redirect, inst_valid, inst_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instruction, inst_pc;

  logic        w_reset = 1'b0;
  logic        w_imem_req, w_imem_ready, w_redirect, w_inst_valid, w_inst_ready;
  logic [31:0] w_imem_addr, w_imem_rdata, w_redirect_pc, w_instruction, w_inst_pc;

  assign imem_rdata   = imem_addr + 32'h1000;
  assign w_imem_rdata = w_imem_addr + 32'h1000;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .instruction(instruction), .inst_pc(inst_pc)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_w (
    .clock(clock), .reset(w_reset), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ready(w_imem_ready), .imem_rdata(w_imem_rdata), .redirect(w_redirect),
    .redirect_pc(w_redirect_pc), .inst_valid(w_inst_valid), .inst_ready(w_inst_ready),
    .instruction(w_instruction), .inst_pc(w_inst_pc)
  );

  typedef struct {
    bit          rst;
    bit          tchk;
    bit          rdy, irdy, redir;
    logic [31:0] rpc;
    bit          req;
    logic [31:0] addr;
    bit          vld;
    logic [31:0] pc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  int errors = 0;
  int checks = 0;

  ent_t        mq[$];
  logic [31:0] mpc, mhold;
  bit          mdrain;
  vec_t        tab[$];

  function automatic vec_t V(bit rst, bit rdy, bit irdy, bit redir, logic [31:0] rpc,
                             bit req, logic [31:0] addr, bit vld, logic [31:0] pc);
    vec_t v;
    v.rst = rst; v.tchk = 1'b1; v.rdy = rdy; v.irdy = irdy; v.redir = redir; v.rpc = rpc;
    v.req = req; v.addr = addr; v.vld = vld; v.pc = pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; imem_ready = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_instr", instruction, 0);
    chk("rst_pc", inst_pc, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    mq.delete(); mpc = 32'h0; mhold = 32'h0; mdrain = 1'b0;
  endtask

  // Drive one cycle, compare against the model (and the table entry if present), then advance.
  task automatic step(input vec_t v);
    bit er, ev, hs, pop;
    logic [31:0] ea;
    ent_t e;
    imem_ready = v.rdy; inst_ready = v.irdy; redirect = v.redir; redirect_pc = v.rpc;
    #1;
    er = mdrain || (mq.size() < DEPTH);
    ea = mdrain ? mhold : mpc;
    ev = (mq.size() != 0) && !v.redir;
    chk("m_req", imem_req, er);
    chk("m_addr", imem_addr, ea);
    chk("m_valid", inst_valid, ev);
    if (ev) begin
      chk("m_pc", inst_pc, mq[0].pc);
      chk("m_instr", instruction, mq[0].word);
    end
    if (v.tchk) begin
      chk("t_req", imem_req, v.req);
      chk("t_addr", imem_addr, v.addr);
      chk("t_valid", inst_valid, v.vld);
      if (v.vld) begin
        chk("t_pc", inst_pc, v.pc);
        chk("t_instr", instruction, v.pc + 32'h1000);
      end
    end
    hs  = er && v.rdy;
    pop = ev && v.irdy;
    if (v.redir) begin
      mq.delete();
      if (!mdrain && er && !v.rdy) begin
        mdrain = 1'b1; mhold = mpc;
      end else if (mdrain && v.rdy) begin
        mdrain = 1'b0;
      end
      mpc = {v.rpc[31:2], 2'b00};
    end else if (mdrain) begin
      if (v.rdy) mdrain = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (hs) begin
        e.pc = mpc; e.word = mpc + 32'h1000;
        mq.push_back(e);
        mpc = mpc + 32'd4;
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    vec_t rv;
    logic [31:0] wpcs [4];

    // Zero-wait stream, inst_ready high.
    tab.push_back(V(1, 1, 1, 0, 0, 1, 32'h00, 0, 0));
    tab.push_back(V(0, 1, 1, 0, 0, 1, 32'h04, 1, 32'h00));
    tab.push_back(V(0, 1, 1, 0, 0, 1, 32'h08, 1, 32'h04));
    tab.push_back(V(0, 1, 1, 0, 0, 1, 32'h0C, 1, 32'h08));
    tab.push_back(V(0, 1, 1, 0, 0, 1, 32'h10, 1, 32'h0C));
    tab.push_back(V(0, 1, 1, 0, 0, 1, 32'h14, 1, 32'h10));
    // Consumer stalled 5 cycles: queue fills, request drops, resumes after a pop.
    tab.push_back(V(1, 1, 0, 0, 0, 1, 32'h00, 0, 0));
    tab.push_back(V(0, 1, 0, 0, 0, 1, 32'h04, 1, 32'h00));
    tab.push_back(V(0, 1, 0, 0, 0, 0, 32'h08, 1, 32'h00));
    tab.push_back(V(0, 1, 0, 0, 0, 0, 32'h08, 1, 32'h00));
    tab.push_back(V(0, 1, 0, 0, 0, 0, 32'h08, 1, 32'h00));
    tab.push_back(V(0, 1, 1, 0, 0, 0, 32'h08, 1, 32'h00));
    tab.push_back(V(0, 1, 1, 0, 0, 1, 32'h08, 1, 32'h04));
    tab.push_back(V(0, 1, 1, 0, 0, 1, 32'h0C, 1, 32'h08));
    // Memory answering every third cycle.
    tab.push_back(V(1, 0, 1, 0, 0, 1, 32'h00, 0, 0));
    tab.push_back(V(0, 0, 1, 0, 0, 1, 32'h00, 0, 0));
    tab.push_back(V(0, 1, 1, 0, 0, 1, 32'h00, 0, 0));
    tab.push_back(V(0, 0, 1, 0, 0, 1, 32'h04, 1, 32'h00));
    tab.push_back(V(0, 0, 1, 0, 0, 1, 32'h04, 0, 0));
    tab.push_back(V(0, 1, 1, 0, 0, 1, 32'h04, 0, 0));
    tab.push_back(V(0, 0, 1, 0, 0, 1, 32'h08, 1, 32'h04));
    // Redirect to 0x40 with a request to 0x10 pending: drain, then fetch target.
    tab.push_back(V(1, 1, 1, 0, 0, 1, 32'h00, 0, 0));
    tab.push_back(V(0, 1, 1, 0, 0, 1, 32'h04, 1, 32'h00));
    tab.push_back(V(0, 1, 1, 0, 0, 1, 32'h08, 1, 32'h04));
    tab.push_back(V(0, 1, 1, 0, 0, 1, 32'h0C, 1, 32'h08));
    tab.push_back(V(0, 0, 1, 1, 32'h40, 1, 32'h10, 0, 0));
    tab.push_back(V(0, 0, 1, 0, 0, 1, 32'h10, 0, 0));
    tab.push_back(V(0, 1, 1, 0, 0, 1, 32'h10, 0, 0));
    tab.push_back(V(0, 1, 1, 0, 0, 1, 32'h40, 0, 0));
    tab.push_back(V(0, 1, 1, 0, 0, 1, 32'h44, 1, 32'h40));
    // Redirect to 0x83 coinciding with a completed handshake.
    tab.push_back(V(1, 1, 1, 0, 0, 1, 32'h00, 0, 0));
    tab.push_back(V(0, 1, 1, 1, 32'h83, 1, 32'h04, 0, 0));
    tab.push_back(V(0, 1, 1, 0, 0, 1, 32'h80, 0, 0));
    tab.push_back(V(0, 1, 1, 0, 0, 1, 32'h84, 1, 32'h80));

    w_imem_ready = 1'b0; w_inst_ready = 1'b0; w_redirect = 1'b0; w_redirect_pc = '0;

    foreach (tab[i]) begin
      if (tab[i].rst) do_reset();
      step(tab[i]);
    end

    do_reset();
    for (int n = 0; n < 600; n++) begin
      rv = V(0, ($urandom_range(9) < 7), ($urandom_range(9) < 7), ($urandom_range(9) == 0),
             $urandom, 0, 0, 0, 0);
      rv.tchk = 1'b0;
      step(rv);
    end

    // Second instance: reset state, PC wrap, then reset mid-stream.
    chk("w_rst_req", w_imem_req, 0);
    chk("w_rst_addr", w_imem_addr, 32'hFFFF_FFF8);
    chk("w_rst_valid", w_inst_valid, 0);
    wpcs[0] = 32'hFFFF_FFF8; wpcs[1] = 32'hFFFF_FFFC; wpcs[2] = 32'h0; wpcs[3] = 32'h4;
    w_imem_ready = 1'b1; w_inst_ready = 1'b1;
    w_reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("w_req", w_imem_req, 1);
      chk("w_addr", w_imem_addr, wpcs[i]);
      chk("w_valid", w_inst_valid, (i > 0));
      if (i > 0) begin
        chk("w_pc", w_inst_pc, wpcs[i-1]);
        chk("w_instr", w_instruction, wpcs[i-1] + 32'h1000);
      end
      @(posedge clock);
      #1;
    end
    w_reset = 1'b0;
    #1;
    chk("w_midrst_req", w_imem_req, 0);
    chk("w_midrst_valid", w_inst_valid, 0);
    chk("w_midrst_addr", w_imem_addr, 32'hFFFF_FFF8);
    chk("w_midrst_pc", w_inst_pc, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
